// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//  - op codes for MULT/MULTU/DIV/DIVU
//  - FSM state encoding
//  - small decode helpers used by the top and the testbench
package mult_div_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    OCIOSO = 2'b00,
    CALC   = 2'b01,
    AJUSTE = 2'b10
  } estado_t;

  // bit 1 selects divide, bit 0 selects unsigned
  function automatic logic eh_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic eh_sinal(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Bus between the EX stage and the multiply/divide unit.
//  master (pipeline): drives limpar, inicio, op, a, b, escreve_hi/lo, dado_hilo
//  slave  (unit)    : drives hi, lo, ocupado, pronto
interface mult_div_unit_if #(parameter int LARGURA = 32);
  logic               limpar;
  logic               inicio;
  logic [1:0]         op;
  logic [LARGURA-1:0] a;
  logic [LARGURA-1:0] b;
  logic               escreve_hi;
  logic               escreve_lo;
  logic [LARGURA-1:0] dado_hilo;
  logic [LARGURA-1:0] hi;
  logic [LARGURA-1:0] lo;
  logic               ocupado;
  logic               pronto;

  modport master (
    output limpar, inicio, op, a, b, escreve_hi, escreve_lo, dado_hilo,
    input  hi, lo, ocupado, pronto
  );

  modport slave (
    input  limpar, inicio, op, a, b, escreve_hi, escreve_lo, dado_hilo,
    output hi, lo, ocupado, pronto
  );
endinterface

// File: rtl/mult_div_unit_passo_div.sv
// One combinational restoring-division step.
//  i_resto   : partial remainder (always < divisor when divisor != 0)
//  i_divisor : divisor magnitude
//  i_bit     : next dividend bit shifted in
//  o_resto   : new partial remainder
//  o_q       : quotient bit produced by this step
module passo_div #(parameter int LARGURA = 32) (
  input  logic [LARGURA-1:0] i_resto,
  input  logic [LARGURA-1:0] i_divisor,
  input  logic               i_bit,
  output logic [LARGURA-1:0] o_resto,
  output logic               o_q
);
  logic [LARGURA:0]   w_desl;
  logic [LARGURA-1:0] w_dif;

  assign w_desl = {i_resto, i_bit};
  // When the subtract succeeds the result is < divisor, so the low bits alone
  // give the exact difference.
  assign w_dif   = w_desl[LARGURA-1:0] - i_divisor;
  assign o_q     = (w_desl >= {1'b0, i_divisor});
  assign o_resto = o_q ? w_dif : w_desl[LARGURA-1:0];
endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning HI/LO.
//  clock, reset_n : clock and async active-low reset
//  bus (slave)    : start/flush/op/operands, mthi/mtlo writes, hi/lo/ocupado/pronto
// An op occupies the unit for LARGURA CALC cycles plus one AJUSTE cycle.
// Operands are reduced to magnitudes on entry; signs are applied in AJUSTE.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int LARGURA = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  mult_div_unit_if.slave  bus
);
  localparam int CW = (LARGURA > 1) ? $clog2(LARGURA) : 1;
  localparam logic [CW-1:0] ULTIMO = CW'(LARGURA - 1);

  estado_t              r_state, w_prox;
  logic [CW-1:0]        r_cnt;
  logic [2*LARGURA-1:0] r_acc;   // mult: {partial sum, multiplier}; div: {remainder, dividend/quotient}
  logic [LARGURA-1:0]   r_opb;   // multiplicand or divisor magnitude
  logic [LARGURA-1:0]   r_a;     // raw dividend, returned in hi on divide by zero
  logic                 r_div;
  logic                 r_bzero;
  logic                 r_neg_lo; // sign of product / quotient
  logic                 r_neg_hi; // sign of remainder
  logic [LARGURA-1:0]   r_hi, r_lo;
  logic                 r_ocupado, r_pronto;

  logic                 w_aceita;
  logic                 w_sinal;
  logic [LARGURA-1:0]   w_mag_a, w_mag_b;
  logic [LARGURA:0]     w_soma;
  logic [2*LARGURA-1:0] w_acc_mul, w_acc_div, w_prod;
  logic [LARGURA-1:0]   w_resto;
  logic                 w_q;
  logic [LARGURA-1:0]   w_quo, w_rem;

  assign w_aceita = (r_state == OCIOSO) && bus.inicio && !bus.limpar;
  assign w_sinal  = eh_sinal(bus.op);
  assign w_mag_a  = (w_sinal && bus.a[LARGURA-1]) ? -bus.a : bus.a;
  assign w_mag_b  = (w_sinal && bus.b[LARGURA-1]) ? -bus.b : bus.b;

  // shift-add step: conditionally add multiplicand to the upper half, shift right
  assign w_soma    = {1'b0, r_acc[2*LARGURA-1:LARGURA]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_acc_mul = {w_soma, r_acc[LARGURA-1:1]};

  passo_div #(.LARGURA(LARGURA)) u_passo (
    .i_resto   (r_acc[2*LARGURA-1:LARGURA]),
    .i_divisor (r_opb),
    .i_bit     (r_acc[LARGURA-1]),
    .o_resto   (w_resto),
    .o_q       (w_q)
  );
  assign w_acc_div = {w_resto, r_acc[LARGURA-2:0], w_q};

  assign w_prod = r_neg_lo ? -r_acc : r_acc;
  assign w_quo  = r_neg_lo ? -r_acc[LARGURA-1:0] : r_acc[LARGURA-1:0];
  assign w_rem  = r_neg_hi ? -r_acc[2*LARGURA-1:LARGURA] : r_acc[2*LARGURA-1:LARGURA];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= OCIOSO;
    else          r_state <= w_prox;
  end

  always_comb begin
    w_prox = r_state;
    case (r_state)
      OCIOSO:  if (w_aceita) w_prox = CALC;
      CALC:    if (bus.limpar) w_prox = OCIOSO;
               else if (r_cnt == ULTIMO) w_prox = AJUSTE;
      AJUSTE:  w_prox = OCIOSO;
      default: w_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opb     <= '0;
      r_a       <= '0;
      r_div     <= 1'b0;
      r_bzero   <= 1'b0;
      r_neg_lo  <= 1'b0;
      r_neg_hi  <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_ocupado <= 1'b0;
      r_pronto  <= 1'b0;
    end else begin
      r_ocupado <= (w_prox != OCIOSO);
      r_pronto  <= (r_state == AJUSTE) && !bus.limpar;
      case (r_state)
        OCIOSO: begin
          if (bus.escreve_hi) r_hi <= bus.dado_hilo;
          if (bus.escreve_lo) r_lo <= bus.dado_hilo;
          if (w_aceita) begin
            r_cnt    <= '0;
            r_acc    <= {{LARGURA{1'b0}}, w_mag_a};
            r_opb    <= w_mag_b;
            r_a      <= bus.a;
            r_div    <= eh_div(bus.op);
            r_bzero  <= (bus.b == '0);
            r_neg_lo <= w_sinal && (bus.a[LARGURA-1] ^ bus.b[LARGURA-1]);
            r_neg_hi <= w_sinal && bus.a[LARGURA-1];
          end
        end
        CALC: begin
          if (!bus.limpar) begin
            r_acc <= r_div ? w_acc_div : w_acc_mul;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        AJUSTE: begin
          if (!bus.limpar) begin
            if (!r_div) begin
              {r_hi, r_lo} <= w_prod;
            end else if (r_bzero) begin
              r_hi <= r_a;
              r_lo <= '1;
            end else begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;
  assign bus.ocupado = r_ocupado;
  assign bus.pronto  = r_pronto;
endmodule
